// File: rtl/ca_pkg.sv
// ca_pkg: shared FSM state, group count and group index type for the step scheduler
package ca_pkg;
  localparam int NGRP = 4;
  typedef logic [1:0] grp_t;
  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
  function automatic grp_t lowest(input logic [NGRP-1:0] v);
    lowest = '0;
    for (int i = NGRP - 1; i >= 0; i--) if (v[i]) lowest = grp_t'(i);
  endfunction
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: two-flop synchronizer plus rising-edge detector for one raw button
module btn_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);
  logic s1, s2, prev;
  logic [2:0] valid;
  // valid shifts in ones after reset so a button held through reset never reads as a fresh edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      prev <= 1'b0;
      valid <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      prev <= s2;
      valid <= {valid[1:0], 1'b1};
    end
  end
  assign rise = s2 & ~prev & valid[2];
endmodule

// File: rtl/ca_step_sched.sv
// ca_step_sched: schedules per-group update strobes from buttons, auto sweeps and seed load/restart
module ca_step_sched
  import ca_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int GEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn,
  input  logic             auto_en,
  input  logic [1:0]       rate_sel,
  input  logic             load_req,
  input  logic             restart_req,
  output logic [3:0]       grp_step,
  output logic             load_pulse,
  output logic             restart_pulse,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output logic             overrun
);
  logic [NGRP-1:0] rise, pending, done_mask, mask_nx, svc_oh;
  state_t state;
  logic sweep_active, decide, svc, tick;
  grp_t sweep_idx, svc_g;
  logic [31:0] cnt, period;
  logic [1:0] rate_q;
  for (genvar g = 0; g < NGRP; g++) begin : g_sync
    btn_edge_sync u_sync (.clk(clk), .reset(reset), .btn(btn[g]), .rise(rise[g]));
  end
  // next-service selection: an active sweep outranks manual requests; the cycle right after a seed pulse is a forced gap
  always_comb begin
    period = 32'(TICK_DIV) >> rate_sel;
    tick = auto_en && (rate_sel == rate_q) && (cnt == period - 32'd1);
    svc = sweep_active || (|pending);
    svc_g = sweep_active ? sweep_idx : lowest(pending);
    svc_oh = NGRP'(1) << svc_g;
    mask_nx = done_mask | svc_oh;
    decide = (state == IDLE) || (state == GAP && !load_pulse && !restart_pulse);
  end
  assign busy = (state != IDLE) || (|pending) || sweep_active;
  // auto tick divider restarts whenever auto mode is off or the rate changes
  always_ff @(posedge clk) begin
    rate_q <= reset ? 2'd0 : rate_sel;
    cnt <= (reset || !auto_en || rate_sel != rate_q || tick) ? 32'd0 : cnt + 32'd1;
  end
  // scheduler FSM with registered strobes, request bookkeeping and generation counting
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      grp_step <= '0;
      load_pulse <= 1'b0;
      restart_pulse <= 1'b0;
      gen_count <= '0;
      overrun <= 1'b0;
      pending <= '0;
      done_mask <= '0;
      sweep_active <= 1'b0;
      sweep_idx <= '0;
    end else if (load_req || restart_req) begin
      state <= GAP;
      grp_step <= '0;
      load_pulse <= load_req;
      restart_pulse <= !load_req;
      gen_count <= '0;
      pending <= '0;
      done_mask <= '0;
      sweep_active <= 1'b0;
      sweep_idx <= '0;
      if (load_req) overrun <= 1'b0;
    end else begin
      load_pulse <= 1'b0;
      restart_pulse <= 1'b0;
      state <= (state == ISSUE) ? GAP : (decide && svc) ? ISSUE : decide ? IDLE : GAP;
      grp_step <= (decide && svc) ? svc_oh : '0;
      if (decide && svc) begin
        pending <= (pending & ~svc_oh) | rise;
        done_mask <= (&mask_nx) ? '0 : mask_nx;
        if (&mask_nx) gen_count <= gen_count + GEN_W'(1);
        if (sweep_active) begin
          sweep_idx <= grp_t'(sweep_idx + 1'b1);
          sweep_active <= (sweep_idx != grp_t'(NGRP - 1));
        end
      end else pending <= pending | rise;
      if (tick && sweep_active) overrun <= 1'b1;
      if (tick && !sweep_active) begin
        sweep_active <= 1'b1;
        sweep_idx <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ca_step_sched.sv
// tb_ca_step_sched: table vectors, corner sequences and a randomized run against a timestamp/queue model
module tb_ca_step_sched;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] btn = '0;
  logic auto_en = 1'b0, load_req = 1'b0, restart_req = 1'b0;
  logic [1:0] rate_sel = '0;
  logic [3:0] grp_step;
  logic load_pulse, restart_pulse, busy, overrun;
  logic [15:0] gen_count;
  int n_cmp = 0, n_bad = 0;

  ca_step_sched #(.TICK_DIV(16), .GEN_W(16)) dut (
    .clk(clk), .reset(reset), .btn(btn), .auto_en(auto_en), .rate_sel(rate_sel),
    .load_req(load_req), .restart_req(restart_req), .grp_step(grp_step),
    .load_pulse(load_pulse), .restart_pulse(restart_pulse), .gen_count(gen_count),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit check);
    btn = '0; auto_en = 1'b0; rate_sel = '0; load_req = 1'b0; restart_req = 1'b0;
    reset = 1'b1;
    step();
    if (check) begin
      chk("rst_grp", grp_step, 0);
      chk("rst_load", load_pulse, 0);
      chk("rst_restart", restart_pulse, 0);
      chk("rst_gen", gen_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
    end
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  // reference model: issue slots tracked by timestamps, sweep as a queue of groups
  logic [3:0] h0, h1, h2, mpend, seen, e_grp;
  logic [15:0] mgen;
  logic movr, e_lp, e_rp, e_busy;
  logic [1:0] rprev;
  int k, t, last_s, last_p;
  int q[$];

  task automatic model_init();
    h0 = '0; h1 = '0; h2 = '0; mpend = '0; seen = '0; mgen = '0; movr = 1'b0;
    rprev = '0; k = 0; t = 0; last_s = -100; last_p = -100; q.delete();
  endtask

  task automatic model_edge();
    logic [3:0] rise;
    logic tk, old_sw;
    int per, g;
    t++;
    rise = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = btn;
    per = 16 >> rate_sel;
    if (auto_en && rate_sel == rprev) k++; else k = 0;
    rprev = rate_sel;
    tk = (k != 0) && (k % per == 0);
    e_grp = '0; e_lp = 1'b0; e_rp = 1'b0;
    if (load_req || restart_req) begin
      e_lp = load_req; e_rp = !load_req;
      mpend = '0; seen = '0; mgen = '0; q.delete(); last_p = t;
      if (load_req) movr = 1'b0;
    end else begin
      old_sw = q.size() != 0;
      g = -1;
      if (t - last_s >= 2 && t - last_p >= 2) begin
        if (old_sw) g = q.pop_front();
        else for (int i = 3; i >= 0; i--) if (mpend[i]) g = i;
      end
      if (g >= 0) begin
        e_grp = 4'b0001 << g;
        mpend[g] = 1'b0;
        seen[g] = 1'b1;
        last_s = t;
        if (seen == 4'hf) begin seen = '0; mgen++; end
      end
      mpend |= rise;
      if (tk) begin
        if (old_sw) movr = 1'b1;
        else q = {0, 1, 2, 3};
      end
    end
    e_busy = (t - last_s <= 1) || (t - last_p <= 1) || mpend != 0 || q.size() != 0;
  endtask

  typedef struct {
    logic [3:0] b;
    logic [3:0] first;
    int n;
    logic [15:0] gen;
  } vec_t;
  vec_t vt[6];

  initial begin
    int nstb, hits;
    bit found;
    vt[0] = '{4'b0100, 4'b0100, 1, 16'd0};
    vt[1] = '{4'b1111, 4'b0001, 4, 16'd1};
    vt[2] = '{4'b0011, 4'b0001, 2, 16'd0};
    vt[3] = '{4'b1000, 4'b1000, 1, 16'd0};
    vt[4] = '{4'b0000, 4'b0000, 0, 16'd0};
    vt[5] = '{4'b0110, 4'b0010, 2, 16'd0};

    do_reset(1);
    for (int v = 0; v < 6; v++) begin
      do_reset(0);
      btn = vt[v].b;
      nstb = 0;
      for (int c = 1; c <= 14; c++) begin
        step();
        if (c == 10) btn = '0;
        if (grp_step != 0) nstb++;
        if (c < 4) chk("tbl_early", grp_step, 0);
        if (c == 4) chk("tbl_first", grp_step, vt[v].first);
        if (v == 1 && c == 10) chk("tbl_last_strobe", grp_step, 4'b1000);
        if (v == 1 && c == 10) chk("tbl_gen_with_last", gen_count, 1);
      end
      chk("tbl_nstrobe", nstb, vt[v].n);
      chk("tbl_gen", gen_count, vt[v].gen);
      chk("tbl_busy_end", busy, 0);
    end

    // colliding auto sweeps
    do_reset(0);
    auto_en = 1'b1; rate_sel = 2'd2;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (c == 8) chk("ovr_before", overrun, 0);
      if (c == 9) chk("ovr_set", overrun, 1);
      if (c == 11) chk("ovr_gen0", gen_count, 0);
      if (c == 12) chk("ovr_last_grp", grp_step, 4'b1000);
      if (c == 12) chk("ovr_gen1", gen_count, 1);
      if (c == 20) chk("ovr_gen2", gen_count, 2);
    end
    auto_en = 1'b0;
    for (int c = 0; c < 12; c++) step();
    chk("ovr_sticky", overrun, 1);

    // load aborting a sweep after its group-1 strobe
    do_reset(0);
    auto_en = 1'b1; rate_sel = 2'd0;
    hits = 0;
    found = 1'b0;
    for (int c = 0; c < 80 && !found; c++) begin
      step();
      if (grp_step == 4'b0010) hits++;
      if (hits == 2) found = 1'b1;
    end
    chk("load_found_g1", found, 1);
    chk("load_gen_before", gen_count, 1);
    auto_en = 1'b0; load_req = 1'b1;
    step();
    load_req = 1'b0;
    chk("load_pulse", load_pulse, 1);
    chk("load_grp", grp_step, 0);
    chk("load_gen", gen_count, 0);
    chk("load_busy_gap", busy, 1);
    step();
    chk("load_pulse_once", load_pulse, 0);
    chk("load_busy_gap2", busy, 1);
    step();
    chk("load_busy_fall", busy, 0);
    nstb = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (grp_step != 0) nstb++;
    end
    chk("load_no_more_strobe", nstb, 0);

    // coincident load and restart
    do_reset(0);
    load_req = 1'b1; restart_req = 1'b1;
    step();
    load_req = 1'b0; restart_req = 1'b0;
    chk("both_load", load_pulse, 1);
    chk("both_restart", restart_pulse, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("both_restart_never", restart_pulse, 0);
    end

    // reset during a strobe
    do_reset(0);
    btn = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      if (grp_step != 0) found = 1'b1;
    end
    chk("rst_issue_found", found, 1);
    btn = 4'b1111; reset = 1'b1;
    step();
    chk("rst_mid_grp", grp_step, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_gen", gen_count, 0);
    step();
    step();
    reset = 1'b0;
    nstb = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (grp_step != 0) nstb++;
    end
    chk("rst_held_no_strobe", nstb, 0);
    chk("rst_held_busy", busy, 0);

    // randomized run against the model
    do_reset(0);
    model_init();
    for (int i = 0; i < 3000; i++) begin
      load_req = 1'b0; restart_req = 1'b0;
      if (i >= 4 && $urandom_range(0, 5) == 0) btn = btn ^ (4'b0001 << $urandom_range(0, 3));
      if ($urandom_range(0, 150) == 0) auto_en = ~auto_en;
      if ($urandom_range(0, 250) == 0) rate_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 120) == 0) load_req = 1'b1;
      if ($urandom_range(0, 120) == 0) restart_req = 1'b1;
      if (i == 10) auto_en = 1'b1;
      model_edge();
      step();
      chk("rnd_grp", grp_step, e_grp);
      chk("rnd_load", load_pulse, e_lp);
      chk("rnd_restart", restart_pulse, e_rp);
      chk("rnd_gen", gen_count, mgen);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_overrun", overrun, movr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
